// File: rtl/stopwatch_timebase_counter_pkg.sv
// Shared stopwatch definitions: FSM state encoding, BCD digit radix limits
// and display geometry.
package stopwatch_timebase_counter_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DISP_W     = DIGIT_W * NUM_DIGITS;

  // Highest value held by a decimal digit and by a tens-of-seconds digit.
  localparam logic [DIGIT_W-1:0] BCD_MAX_9 = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MAX_5 = 4'd5;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_PAUSE = 2'd2
  } sw_state_e;

endpackage : stopwatch_timebase_counter_pkg

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counter, one link of the stopwatch carry chain.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   inc        : advance the digit by one (modulo max+1)
//   clr        : synchronous clear to zero, takes priority over inc
//   max        : highest digit value before wrap
//   digit      : current digit value
//   carry      : combinational; high when inc wraps this digit back to zero
module bcd_digit_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  input  logic [3:0] max,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;
  logic       at_max;

  // >= keeps the digit inside its radix even if it ever held a larger value.
  assign at_max = (digit_q >= max);
  assign carry  = inc & ~clr & at_max;
  assign digit  = digit_q;

  // Next digit value.
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = 4'd0;
    end else if (inc) begin
      digit_d = at_max ? 4'd0 : digit_q + 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule : bcd_digit_cnt

// File: rtl/stopwatch_timebase_counter.sv
// Stopwatch timebase: counts centisecond ticks from the divided 100 Hz
// level into MM:SS.CC BCD digits under a run/pause/lap/clear FSM.
// Ports:
//   clk_base    : system clock
//   reset       : asynchronous, active-high reset
//   tick_in     : divided clock level, each rising edge is one centisecond
//   start_stop  : single-cycle pulse, toggles run/pause
//   lap_clr     : single-cycle pulse, lap toggle when running, clear when paused
//   disp_digits : {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, held or live time
//   running     : high while in the run state
//   lap_hold    : high while the display is frozen on a lap value
//   overflow    : sticky, set when the time wraps back to 00:00.00
module stopwatch_timebase_counter
  import stopwatch_timebase_counter_pkg::*;
#(
  parameter int unsigned MIN_TENS_MAX = 5,
  parameter int unsigned TICK_RST_LVL = 1
) (
  input  logic        clk_base,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        start_stop,
  input  logic        lap_clr,
  output logic [23:0] disp_digits,
  output logic        running,
  output logic        lap_hold,
  output logic        overflow
);

  sw_state_e state_q;
  sw_state_e state_d;

  logic tick_q;
  logic tick_evt;

  logic count_en;
  logic lap_toggle;
  logic clr_all;

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] live;
  logic [NUM_DIGITS-1:0]              dig_inc;
  logic [NUM_DIGITS-1:0]              dig_carry;

  logic [DISP_W-1:0] held_q;
  logic [DISP_W-1:0] held_d;
  logic              lap_hold_q;
  logic              lap_hold_d;
  logic              overflow_q;
  logic              overflow_d;
  logic              running_q;

  // Rising-edge detect on the tick level; the sampler resets to the divider's
  // reset level so releasing reset cannot fabricate an edge.
  always_ff @(posedge clk_base or posedge reset) begin
    if (reset) begin
      tick_q <= 1'(TICK_RST_LVL);
    end else begin
      tick_q <= tick_in;
    end
  end

  assign tick_evt = tick_in & ~tick_q;

  // FSM state register.
  always_ff @(posedge clk_base or posedge reset) begin
    if (reset) begin
      state_q <= SW_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; start_stop always wins over lap_clr.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SW_IDLE:  if (start_stop) state_d = SW_RUN;
      SW_RUN:   if (start_stop) state_d = SW_PAUSE;
      SW_PAUSE: begin
        if (start_stop) begin
          state_d = SW_RUN;
        end else if (lap_clr) begin
          state_d = SW_IDLE;
        end
      end
      default:  state_d = SW_IDLE;
    endcase
  end

  // FSM outputs: count enable, lap toggle and clear strobes.
  always_comb begin
    count_en   = 1'b0;
    lap_toggle = 1'b0;
    clr_all    = 1'b0;
    unique case (state_q)
      SW_RUN: begin
        count_en   = tick_evt;
        lap_toggle = lap_clr & ~start_stop;
      end
      SW_PAUSE: clr_all = lap_clr & ~start_stop;
      default: ;
    endcase
  end

  // Digit chain, index 0 = cs_u up to index 5 = min_t.
  assign dig_inc[0] = count_en;
  assign dig_inc[NUM_DIGITS-1:1] = dig_carry[NUM_DIGITS-2:0];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : gen_digit
    localparam logic [DIGIT_W-1:0] DIG_MAX =
      (i == 5) ? DIGIT_W'(MIN_TENS_MAX) :
      (i == 3) ? BCD_MAX_5 : BCD_MAX_9;

    bcd_digit_cnt u_digit (
      .clk   (clk_base),
      .reset (reset),
      .inc   (dig_inc[i]),
      .clr   (clr_all),
      .max   (DIG_MAX),
      .digit (live[i]),
      .carry (dig_carry[i])
    );
  end

  // Lap latch and sticky overflow; capture takes the pre-increment live value.
  always_comb begin
    held_d     = held_q;
    lap_hold_d = lap_hold_q;
    overflow_d = overflow_q;
    if (clr_all) begin
      held_d     = '0;
      lap_hold_d = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (lap_toggle) begin
        if (!lap_hold_q) begin
          held_d     = live;
          lap_hold_d = 1'b1;
        end else begin
          lap_hold_d = 1'b0;
        end
      end
      if (dig_carry[NUM_DIGITS-1]) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Lap, overflow and status registers.
  always_ff @(posedge clk_base or posedge reset) begin
    if (reset) begin
      held_q     <= '0;
      lap_hold_q <= 1'b0;
      overflow_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      held_q     <= held_d;
      lap_hold_q <= lap_hold_d;
      overflow_q <= overflow_d;
      running_q  <= (state_d == SW_RUN);
    end
  end

  // Display selects between registered held and live values.
  assign disp_digits = lap_hold_q ? held_q : live;
  assign running     = running_q;
  assign lap_hold    = lap_hold_q;
  assign overflow    = overflow_q;

endmodule : stopwatch_timebase_counter

// File: tb/tb_stopwatch_timebase_counter.sv
// Self-checking bench for stopwatch_timebase_counter: directed scenarios plus
// random control/tick traffic against a centisecond-integer reference model.
module tb_stopwatch_timebase_counter;

  localparam int unsigned MTM   = 5;
  localparam int          LIMIT = (MTM + 1) * 10 * 6000;

  logic        clk_base = 1'b0;
  logic        reset;
  logic        tick_in;
  logic        start_stop;
  logic        lap_clr;
  logic [23:0] disp_digits;
  logic        running;
  logic        lap_hold;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: time kept as total centiseconds.
  int m_state;   // 0 idle, 1 running, 2 paused
  int m_cnt;
  int m_held;
  bit m_lap;
  bit m_ovf;
  bit m_tick_prev;

  stopwatch_timebase_counter #(
    .MIN_TENS_MAX (MTM),
    .TICK_RST_LVL (1)
  ) dut (
    .clk_base    (clk_base),
    .reset       (reset),
    .tick_in     (tick_in),
    .start_stop  (start_stop),
    .lap_clr     (lap_clr),
    .disp_digits (disp_digits),
    .running     (running),
    .lap_hold    (lap_hold),
    .overflow    (overflow)
  );

  always #5 clk_base = ~clk_base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [23:0] to_bcd(input int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_held = 0; m_lap = 0; m_ovf = 0; m_tick_prev = 1'b1;
  endtask

  task automatic model_step(input bit t, input bit ss, input bit lc);
    bit evt;
    evt = t & ~m_tick_prev;
    m_tick_prev = t;
    case (m_state)
      0: if (ss) m_state = 1;
      1: begin
        if (lc && !ss) begin
          if (!m_lap) begin m_held = m_cnt; m_lap = 1; end
          else m_lap = 0;
        end
        if (evt) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == LIMIT) begin m_cnt = 0; m_ovf = 1; end
        end
        if (ss) m_state = 2;
      end
      default: begin
        if (ss) m_state = 1;
        else if (lc) begin
          m_state = 0; m_cnt = 0; m_held = 0; m_lap = 0; m_ovf = 0;
        end
      end
    endcase
  endtask

  task automatic check_all();
    check("disp", 32'(disp_digits), 32'(m_lap ? to_bcd(m_held) : to_bcd(m_cnt)));
    check("running", 32'(running), 32'(m_state == 1));
    check("lap_hold", 32'(lap_hold), 32'(m_lap));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: drive at negedge, update model, sample at the next negedge.
  task automatic cyc(input bit t, input bit ss, input bit lc);
    tick_in = t; start_stop = ss; lap_clr = lc;
    model_step(t, ss, lc);
    @(posedge clk_base);
    @(negedge clk_base);
    check_all();
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; tick_in = 1'b1; start_stop = 1'b0; lap_clr = 1'b0;
    model_reset();
    #12;
    check("rst.disp", 32'(disp_digits), 32'h0);
    check("rst.running", 32'(running), 32'h0);
    check("rst.lap_hold", 32'(lap_hold), 32'h0);
    check("rst.overflow", 32'(overflow), 32'h0);
    @(negedge clk_base);
    reset = 1'b0;

    // Reset release with tick high then low: nothing counts.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("release.disp", 32'(disp_digits), 32'h0);

    // 100 ticks = one second.
    cyc(1'b0, 1'b1, 1'b0);
    tick_n(100);
    check("run100.disp", 32'(disp_digits), 32'h000100);
    check("run100.running", 32'(running), 32'h1);

    // Paused: ticks ignored.
    cyc(1'b0, 1'b1, 1'b0);
    tick_n(5);
    check("pause.disp", 32'(disp_digits), 32'h000100);
    check("pause.running", 32'(running), 32'h0);

    // Clear, then lap freeze at 37 and release at 57.
    cyc(1'b0, 1'b0, 1'b1);
    check("clr1.disp", 32'(disp_digits), 32'h0);
    cyc(1'b0, 1'b1, 1'b0);
    tick_n(37);
    cyc(1'b0, 1'b0, 1'b1);
    check("lap.freeze", 32'(disp_digits), 32'h000037);
    check("lap.hold", 32'(lap_hold), 32'h1);
    tick_n(20);
    check("lap.frozen", 32'(disp_digits), 32'h000037);
    cyc(1'b0, 1'b0, 1'b1);
    check("lap.release", 32'(disp_digits), 32'h000057);
    check("lap.unhold", 32'(lap_hold), 32'h0);

    // Clear from pause at 00:12.34, then lap_clr in idle.
    tick_n(1234 - 57);
    cyc(1'b0, 1'b1, 1'b0);
    check("p1234.disp", 32'(disp_digits), 32'h001234);
    cyc(1'b0, 1'b0, 1'b1);
    check("clr.disp", 32'(disp_digits), 32'h0);
    check("clr.overflow", 32'(overflow), 32'h0);
    cyc(1'b0, 1'b0, 1'b1);
    check("idle_lc.disp", 32'(disp_digits), 32'h0);
    check("idle_lc.running", 32'(running), 32'h0);

    // start_stop and lap_clr together while running: pause, lap kept.
    cyc(1'b0, 1'b1, 1'b0);
    tick_n(3);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    check("simul.running", 32'(running), 32'h0);
    check("simul.lap_hold", 32'(lap_hold), 32'h1);
    check("simul.disp", 32'(disp_digits), 32'h000003);
    cyc(1'b0, 1'b1, 1'b0);
    check("resume.lap_hold", 32'(lap_hold), 32'h1);
    cyc(1'b0, 1'b0, 1'b1);
    tick_n(2);
    // Tick counted on the same edge that pauses.
    cyc(1'b1, 1'b1, 1'b0);
    check("tick_ss.disp", 32'(disp_digits), 32'h000006);
    check("tick_ss.running", 32'(running), 32'h0);
    cyc(1'b0, 1'b0, 1'b0);
    // Lap capture on a tick edge keeps the pre-increment value.
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    check("lap_tick.held", 32'(disp_digits), 32'h000006);
    cyc(1'b0, 1'b0, 1'b1);
    check("lap_tick.live", 32'(disp_digits), 32'h000007);

    // Wrap: preload 59:59.99 while idle, then one tick.
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    force dut.gen_digit[5].u_digit.digit_q = 4'(MTM);
    force dut.gen_digit[4].u_digit.digit_q = 4'd9;
    force dut.gen_digit[3].u_digit.digit_q = 4'd5;
    force dut.gen_digit[2].u_digit.digit_q = 4'd9;
    force dut.gen_digit[1].u_digit.digit_q = 4'd9;
    force dut.gen_digit[0].u_digit.digit_q = 4'd9;
    @(posedge clk_base);
    @(negedge clk_base);
    release dut.gen_digit[5].u_digit.digit_q;
    release dut.gen_digit[4].u_digit.digit_q;
    release dut.gen_digit[3].u_digit.digit_q;
    release dut.gen_digit[2].u_digit.digit_q;
    release dut.gen_digit[1].u_digit.digit_q;
    release dut.gen_digit[0].u_digit.digit_q;
    m_cnt = LIMIT - 1;
    check("preload.disp", 32'(disp_digits), 32'h595999);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("wrap.disp", 32'(disp_digits), 32'h000000);
    check("wrap.overflow", 32'(overflow), 32'h1);
    cyc(1'b0, 1'b0, 1'b0);
    tick_n(10);
    check("wrap10.disp", 32'(disp_digits), 32'h000010);
    check("wrap10.overflow", 32'(overflow), 32'h1);
    cyc(1'b0, 1'b1, 1'b0);
    check("wrap_pause.overflow", 32'(overflow), 32'h1);
    cyc(1'b0, 1'b0, 1'b1);
    check("wrap_clr.overflow", 32'(overflow), 32'h0);

    // Random traffic.
    repeat (3000) begin
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0);
    end

    // Async reset mid-run.
    cyc(1'b0, 1'b0, 1'b0);
    if (m_state != 1) cyc(1'b0, 1'b1, 1'b0);
    tick_n(7);
    #2 reset = 1'b1;
    #1;
    check("async.disp", 32'(disp_digits), 32'h0);
    check("async.running", 32'(running), 32'h0);
    check("async.lap_hold", 32'(lap_hold), 32'h0);
    check("async.overflow", 32'(overflow), 32'h0);
    model_reset();
    tick_in = 1'b0;
    @(negedge clk_base);
    reset = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    tick_n(3);
    check("post_rst.disp", 32'(disp_digits), 32'h000003);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_stopwatch_timebase_counter
